// File: rtl/memory_hs_bank.sv
// memory_hs_bank: single-port memory bank behind a valid/ready
// handshake with byte strobes, wait states, range error and clear.
module memory_hs_bank #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH/8-1:0]    wstrb_i,
  input  logic                  clr_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int NB = WIDTH / 8;
  localparam logic [2:0] LP_WS =
    3'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_CLEAR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]            r_wcnt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [NB-1:0]         r_wstrb;
  logic                  r_wr;
  logic                  r_oob;
  logic [WIDTH-1:0]      r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_clr_go;
  logic                  w_enter_resp;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [WIDTH-1:0]      w_wdata;
  logic [NB-1:0]         w_wstrb;
  logic                  w_wr;
  logic                  w_in_range;
  logic                  w_mem_we;
  logic                  w_clr_we;

  // Next-state decode; clear wins over a request in IDLE.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_clr_go     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_i) begin
          w_clr_go = 1'b1;
          w_next   = S_CLEAR;
        end else if (valid_i) begin
          w_accept = 1'b1;
          if (LP_WS != 3'd0) begin
            w_next = S_WAIT;
          end else begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_wcnt <= 3'd1) begin
          w_next       = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      S_CLEAR: begin
        if (r_ptr == LP_LAST) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // With zero wait states the access uses the live payload.
  always_comb begin
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_wstrb = r_wstrb;
    w_wr    = r_wr;
    if (r_state == S_IDLE) begin
      w_addr  = addr_i;
      w_wdata = wdata_i;
      w_wstrb = wstrb_i;
      w_wr    = wr_rd_i;
    end
  end

  assign w_in_range = int'(w_addr) < DEPTH;
  assign w_mem_we   = rst_i & w_enter_resp
                    & w_wr & w_in_range;
  assign w_clr_we   = rst_i & (r_state == S_CLEAR);

  // State, payload latch, counters and read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_wr    <= 1'b0;
      r_oob   <= 1'b0;
      rdata_o <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
        r_wstrb <= wstrb_i;
        r_wr    <= wr_rd_i;
        r_wcnt  <= LP_WS;
      end else if (r_state == S_WAIT &&
                   r_wcnt != 3'd0) begin
        r_wcnt <= r_wcnt - 3'd1;
      end
      if (w_clr_go) begin
        r_ptr <= '0;
      end else if (r_state == S_CLEAR) begin
        if (r_ptr == LP_LAST) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
      if (w_enter_resp) begin
        r_oob <= ~w_in_range;
        if (!w_wr) begin
          if (w_in_range) begin
            rdata_o <= r_mem[w_addr];
          end else begin
            rdata_o <= '0;
          end
        end
      end
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (w_clr_we) begin
      r_mem[r_ptr] <= '0;
    end else if (w_mem_we) begin
      for (int k = 0; k < NB; k++) begin
        if (w_wstrb[k]) begin
          r_mem[w_addr][8*k +: 8] <=
            w_wdata[8*k +: 8];
        end
      end
    end
  end

  assign ready_o  = (r_state == S_RESP);
  assign rvalid_o = ready_o & ~r_wr;
  assign err_o    = ready_o & r_oob;
  assign busy_o   = (r_state == S_CLEAR);

endmodule

// File: tb/tb_memory_hs_bank.sv
// tb_memory_hs_bank: directed bench for three wait-state
// variants of memory_hs_bank (index 0: ws1, 1: ws0, 2: ws7).
module tb_memory_hs_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid [3];
  logic        wr_rd [3];
  logic        clr   [3];
  logic [3:0]  addr  [3];
  logic [15:0] wdata [3];
  logic [1:0]  wstrb [3];
  logic        ready [3];
  logic        rvalid[3];
  logic        err   [3];
  logic        busy  [3];
  logic [15:0] rdata [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_hs_bank #(
    .WIDTH(16), .DEPTH(12),
    .ADDR_WIDTH(4), .WAIT_STATES(1)
  ) u_ws1 (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid[0]), .wr_rd_i(wr_rd[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]),
    .wstrb_i(wstrb[0]), .clr_i(clr[0]),
    .ready_o(ready[0]), .rdata_o(rdata[0]),
    .rvalid_o(rvalid[0]), .err_o(err[0]),
    .busy_o(busy[0])
  );

  memory_hs_bank #(
    .WIDTH(16), .DEPTH(12),
    .ADDR_WIDTH(4), .WAIT_STATES(0)
  ) u_ws0 (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid[1]), .wr_rd_i(wr_rd[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]),
    .wstrb_i(wstrb[1]), .clr_i(clr[1]),
    .ready_o(ready[1]), .rdata_o(rdata[1]),
    .rvalid_o(rvalid[1]), .err_o(err[1]),
    .busy_o(busy[1])
  );

  memory_hs_bank #(
    .WIDTH(16), .DEPTH(12),
    .ADDR_WIDTH(4), .WAIT_STATES(7)
  ) u_ws7 (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid[2]), .wr_rd_i(wr_rd[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]),
    .wstrb_i(wstrb[2]), .clr_i(clr[2]),
    .ready_o(ready[2]), .rdata_o(rdata[2]),
    .rvalid_o(rvalid[2]), .err_o(err[2]),
    .busy_o(busy[2])
  );

  // One full handshake; called at a negedge, returns at one.
  task automatic do_req(
    input  int          k,
    input  logic        w,
    input  logic [3:0]  a,
    input  logic [15:0] d,
    input  logic [1:0]  s,
    output int          lat,
    output logic [15:0] rd,
    output logic        rv,
    output logic        er
  );
    valid[k] = 1'b1;
    wr_rd[k] = w;
    addr[k]  = a;
    wdata[k] = d;
    wstrb[k] = s;
    lat = -1;
    rd  = 'x;
    rv  = 1'bx;
    er  = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) begin
        lat = c;
        rd  = rdata[k];
        rv  = rvalid[k];
        er  = err[k];
        break;
      end
    end
    valid[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int hi;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0;
      wr_rd[k] = 1'b0;
      clr[k]   = 1'b0;
      addr[k]  = '0;
      wdata[k] = '0;
      wstrb[k] = '0;
    end
    #1;
    checks++;
    if ({ready[0], rvalid[0], err[0], busy[0]}
        !== 4'b0 || rdata[0] !== 16'h0) begin
      errors++;
      $display("FAIL reset_outs got %b%b%b%b %h want 0",
        ready[0], rvalid[0], err[0], busy[0],
        rdata[0]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    hi = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready[0] !== 1'b0) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL idle_ready got %0d pulses want 0",
        hi);
    end
  endtask

  task automatic test_sweep();
    int lat;
    logic [15:0] rd;
    logic rv, er;
    for (int i = 0; i < 12; i++) begin
      do_req(0, 1'b1, 4'(i), 16'hA500 + 16'(i),
        2'b11, lat, rd, rv, er);
      checks++;
      if (lat !== 2 || er !== 1'b0 || rv !== 1'b0) begin
        errors++;
        $display("FAIL sweep_wr%0d got lat%0d e%b v%b want lat2 e0 v0",
          i, lat, er, rv);
      end
    end
    for (int i = 0; i < 12; i++) begin
      do_req(0, 1'b0, 4'(i), 16'h0, 2'b00,
        lat, rd, rv, er);
      checks++;
      if (lat !== 2 || rd !== 16'hA500 + 16'(i) ||
          rv !== 1'b1 || er !== 1'b0) begin
        errors++;
        $display("FAIL sweep_rd%0d got lat%0d %h v%b e%b want lat2 %h v1 e0",
          i, lat, rd, rv, er, 16'hA500 + 16'(i));
      end
    end
  endtask

  task automatic test_strobes();
    int lat;
    logic [15:0] rd;
    logic rv, er;
    do_req(0, 1'b1, 4'd3, 16'h1234, 2'b11,
      lat, rd, rv, er);
    do_req(0, 1'b1, 4'd3, 16'hABCD, 2'b01,
      lat, rd, rv, er);
    do_req(0, 1'b0, 4'd3, 16'h0, 2'b00,
      lat, rd, rv, er);
    checks++;
    if (rd !== 16'h12CD || rv !== 1'b1) begin
      errors++;
      $display("FAIL strb_low got %h v%b want 12cd v1",
        rd, rv);
    end
    do_req(0, 1'b1, 4'd3, 16'h5555, 2'b00,
      lat, rd, rv, er);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL strb_none_ready got lat%0d want 2",
        lat);
    end
    do_req(0, 1'b0, 4'd3, 16'h0, 2'b00,
      lat, rd, rv, er);
    checks++;
    if (rd !== 16'h12CD) begin
      errors++;
      $display("FAIL strb_none_data got %h want 12cd",
        rd);
    end
  endtask

  task automatic test_oob();
    int lat;
    logic [15:0] rd, exp;
    logic rv, er;
    do_req(0, 1'b1, 4'd13, 16'hFFFF, 2'b11,
      lat, rd, rv, er);
    checks++;
    if (lat !== 2 || er !== 1'b1 || rv !== 1'b0) begin
      errors++;
      $display("FAIL oob_wr got lat%0d e%b v%b want lat2 e1 v0",
        lat, er, rv);
    end
    for (int i = 0; i < 12; i++) begin
      exp = (i == 3) ? 16'h12CD : 16'hA500 + 16'(i);
      do_req(0, 1'b0, 4'(i), 16'h0, 2'b00,
        lat, rd, rv, er);
      checks++;
      if (rd !== exp || er !== 1'b0) begin
        errors++;
        $display("FAIL oob_sweep%0d got %h e%b want %h e0",
          i, rd, er, exp);
      end
    end
    do_req(0, 1'b0, 4'd15, 16'h0, 2'b00,
      lat, rd, rv, er);
    checks++;
    if (lat !== 2 || er !== 1'b1 || rv !== 1'b1 ||
        rd !== 16'h0) begin
      errors++;
      $display("FAIL oob_rd got lat%0d e%b v%b %h want lat2 e1 v1 0000",
        lat, er, rv, rd);
    end
  endtask

  task automatic test_async_reset();
    int hi;
    logic got;
    valid[0] = 1'b1;
    wr_rd[0] = 1'b0;
    addr[0]  = 4'd5;
    got = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ready[0] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    valid[0] = 1'b0;
    checks++;
    if (got !== 1'b1 || rdata[0] !== 16'hA505) begin
      errors++;
      $display("FAIL arst_pre got r%b %h want r1 a505",
        got, rdata[0]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ready[0], rvalid[0], err[0], busy[0]}
        !== 4'b0 || rdata[0] !== 16'h0) begin
      errors++;
      $display("FAIL arst_outs got %b%b%b%b %h want 0",
        ready[0], rvalid[0], err[0], busy[0],
        rdata[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    hi = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready[0] !== 1'b0) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL arst_idle got %0d pulses want 0",
        hi);
    end
  endtask

  task automatic test_clear();
    int nb, nr, first, lat;
    logic [15:0] rd;
    logic rv, er;
    clr[0]   = 1'b1;
    valid[0] = 1'b1;
    wr_rd[0] = 1'b0;
    addr[0]  = 4'd0;
    nb = 0;
    nr = 0;
    first = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        clr[0]   = 1'b0;
        valid[0] = 1'b0;
      end
      if (busy[0] === 1'b1) begin
        nb++;
        if (first < 0) first = c;
      end
      if (ready[0] !== 1'b0) nr++;
    end
    checks++;
    if (nb !== 12 || first !== 1) begin
      errors++;
      $display("FAIL clr_busy got %0d from %0d want 12 from 1",
        nb, first);
    end
    checks++;
    if (nr !== 0) begin
      errors++;
      $display("FAIL clr_ready got %0d want 0", nr);
    end
    for (int i = 0; i < 12; i++) begin
      do_req(0, 1'b0, 4'(i), 16'h0, 2'b00,
        lat, rd, rv, er);
      checks++;
      if (rd !== 16'h0 || rv !== 1'b1) begin
        errors++;
        $display("FAIL clr_rd%0d got %h v%b want 0000 v1",
          i, rd, rv);
      end
    end
  endtask

  task automatic test_back_to_back(
    input int k,
    input int per
  );
    int t [3];
    int n;
    for (int j = 0; j < 3; j++) t[j] = -1;
    valid[k] = 1'b1;
    wr_rd[k] = 1'b0;
    addr[k]  = 4'd0;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) begin
        t[n] = c;
        n++;
        if (n == 3) break;
      end
    end
    valid[k] = 1'b0;
    @(negedge clk);
    checks++;
    if (t[0] !== per - 1) begin
      errors++;
      $display("FAIL b2b%0d_lat got %0d want %0d",
        k, t[0], per - 1);
    end
    checks++;
    if (t[1] - t[0] !== per || t[2] - t[1] !== per ||
        t[2] < 0) begin
      errors++;
      $display("FAIL b2b%0d_per got %0d,%0d want %0d",
        k, t[1] - t[0], t[2] - t[1], per);
    end
  endtask

  task automatic test_reset_in_wait();
    int lat;
    logic [15:0] rd;
    logic rv, er;
    do_req(2, 1'b1, 4'd2, 16'h1111, 2'b11,
      lat, rd, rv, er);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL ws7_wr_lat got %0d want 8", lat);
    end
    valid[2] = 1'b1;
    wr_rd[2] = 1'b1;
    addr[2]  = 4'd2;
    wdata[2] = 16'h2222;
    wstrb[2] = 2'b11;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_req(2, 1'b0, 4'd2, 16'h0, 2'b00,
      lat, rd, rv, er);
    checks++;
    if (rd !== 16'h1111 || lat !== 8) begin
      errors++;
      $display("FAIL rst_wait got %h lat%0d want 1111 lat8",
        rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_strobes();
    test_oob();
    test_async_reset();
    test_clear();
    test_back_to_back(1, 2);
    test_back_to_back(2, 9);
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
